// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// ALU_SEQ_MUL_EN adds the MUL state used by the iterative multiplier path.
package alu_pkg;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_MUL    = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd3
    } seq_state_t;
`endif

    localparam logic [3:0] OP_MUL = 4'hF;
    localparam int SETTLE_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock, NrOfBits steps, truncated product.
// Only built when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_shift_add_mul #(
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                start,
    input  logic [NrOfBits-1:0] a,
    input  logic [NrOfBits-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [NrOfBits-1:0] product
);
    localparam int CW = $clog2(NrOfBits + 1);

    logic [NrOfBits-1:0] mcand;
    logic [NrOfBits-1:0] mplier;
    logic [CW-1:0]       steps_left;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            mcand      <= '0;
            mplier     <= '0;
            product    <= '0;
            steps_left <= '0;
            busy       <= 1'b0;
        end else if (start) begin
            mcand      <= a;
            mplier     <= b;
            product    <= '0;
            steps_left <= CW'(NrOfBits);
            busy       <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand      <= mcand << 1;
            mplier     <= mplier >> 1;
            steps_left <= steps_left - CW'(1);
            if (steps_left == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge performs the final step.
    assign done = busy && (steps_left == CW'(1));

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU request: registers operands/select, lets the result mux settle, captures the result.
// Define ALU_SEQ_MUL_EN to add the shift-add multiplier on opcode 4'hF (MulOut feeds mux input 15).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NrOfBits     = 32,
    parameter int SettleCycles = SETTLE_CYCLES_DEFAULT
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [3:0]          OpCode,
    input  logic [NrOfBits-1:0] OperandA,
    input  logic [NrOfBits-1:0] OperandB,
    output logic [NrOfBits-1:0] OpA_q,
    output logic [NrOfBits-1:0] OpB_q,
    output logic [3:0]          Sel,
    output logic                MuxEnable,
    input  logic [NrOfBits-1:0] MuxOut,
`ifdef ALU_SEQ_MUL_EN
    output logic [NrOfBits-1:0] MulOut,
`endif
    output logic [NrOfBits-1:0] Result,
    output logic                Zero,
    output logic                ResultValid,
    input  logic                ResultReady
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SettleCycles);

    seq_state_t state;
    seq_state_t next_state;
    logic [3:0] settle_cnt;
    logic       accept;

    assign accept = ReqValid && ReqReady;

`ifdef ALU_SEQ_MUL_EN
    logic mul_start;
    logic mul_busy;
    logic mul_done;

    assign mul_start = accept && (OpCode == OP_MUL);

    alu_shift_add_mul #(
        .NrOfBits(NrOfBits)
    ) u_mul (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .start  (mul_start),
        .a      (OperandA),
        .b      (OperandB),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(MulOut)
    );
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    next_state = mul_start ? ST_MUL : ST_SETTLE;
`else
                    next_state = ST_SETTLE;
`endif
                end
            end
            ST_SETTLE: if (settle_cnt <= 4'd1) next_state = ST_DONE;
`ifdef ALU_SEQ_MUL_EN
            // Leaving on !mul_busy as well keeps the FSM from stranding if the multiplier ever idles early.
            ST_MUL:    if (mul_done || !mul_busy) next_state = ST_SETTLE;
`endif
            ST_DONE:   if (ResultReady) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ReqReady    = 1'b0;
        MuxEnable   = 1'b0;
        ResultValid = 1'b0;
        case (state)
            ST_IDLE:   ReqReady    = 1'b1;
            ST_SETTLE: MuxEnable   = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL:    MuxEnable   = 1'b1;
`endif
            ST_DONE:   ResultValid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            OpA_q      <= '0;
            OpB_q      <= '0;
            Sel        <= '0;
            Result     <= '0;
            settle_cnt <= '0;
        end else if (accept) begin
            OpA_q      <= OperandA;
            OpB_q      <= OperandB;
            Sel        <= OpCode;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) begin
                Result <= MuxOut;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state == ST_MUL && next_state == ST_SETTLE) begin
            settle_cnt <= 4'd1;
        end
`endif
    end

    assign Zero = (Result == '0);

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter NrOfBits, default 32, datapath width of operands/result.
REQ-002 SHALL have parameter SettleCycles, default 1, range 1..15, cycles the selected result path is allowed to settle before capture.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset (one clock; reset synchronous and active-low, fixed).
REQ-005 ReqValid  input  1  operation request present.
REQ-006 ReqReady  output  1  sequencer accepts request this cycle.
REQ-007 OpCode  input  4  operation select, passed to result multiplexer.
REQ-008 OperandA / OperandB  input  NrOfBits each  request operands.
REQ-009 OpA_q / OpB_q  output  NrOfBits each  registered operands feeding the ALU function units.
REQ-010 Sel  output  4  registered select to 16-way result multiplexer.
REQ-011 MuxEnable  output  1  multiplexer enable; high only while an operation is in flight.
REQ-012 MuxOut  input  NrOfBits  selected result from multiplexer.
REQ-013 MulOut  output  NrOfBits  iterative multiplier product, routed to mux input 15 (present only under ALU_SEQ_MUL_EN).
REQ-014 Result  output  NrOfBits  captured result; Zero  output  1  Result == 0.
REQ-015 ResultValid  input-side output  1  Result held valid; ResultReady  input  1  consumer accepts.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, MUL, DONE.
REQ-017 ReqReady SHALL equal 1 exactly in IDLE; request accepted on ReqValid && ReqReady.
REQ-018 On accept: OpA_q, OpB_q, Sel SHALL load OperandA, OperandB, OpCode; MuxEnable SHALL go 1 next cycle; settle counter loads SettleCycles.
REQ-019 Transition IDLE->MUL on accept with OpCode==4'hF (MUL enabled), else IDLE->SETTLE.
REQ-020 SETTLE SHALL decrement counter each cycle; at counter==1 capture MuxOut into Result, go DONE; latency accept-to-ResultValid = SettleCycles+1 cycles.
REQ-021 MUL SHALL perform one shift-add step per cycle (NrOfBits steps), product truncated to low NrOfBits bits, then go SETTLE with counter=1; latency NrOfBits+2 cycles.
REQ-022 DONE: ResultValid=1, Result and Zero stable; on ResultReady go IDLE same edge; MuxEnable=0 in DONE and IDLE.
REQ-023 ResultValid SHALL not drop before ResultReady; back-to-back: new request accepted no earlier than cycle after DONE->IDLE.
REQ-024 OpA_q, OpB_q, Sel SHALL hold constant from accept until DONE exits.
REQ-025 ReqValid while not in IDLE SHALL be ignored (no state change).

Reset
REQ-026 Reset_n low at an edge SHALL force IDLE, ReqReady=1 next cycle, MuxEnable=0, ResultValid=0, Sel=0, OpA_q=OpB_q=0, Result=0, Zero=1, MulOut=0, counters 0.
REQ-027 Reset mid-operation (SETTLE/MUL/DONE) SHALL abort without emitting ResultValid.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: MulOut port, multiplier datapath and MUL state present.
REQ-029 Macro ALU_SEQ_MUL_EN undefined: no MulOut port, no MUL state; OpCode 4'hF follows the SETTLE path like all others.

Structure
REQ-030 Shared package alu_pkg SHALL hold FSM state enum, opcode constant OP_MUL=4'hF, SettleCycles default.
REQ-031 Multiplier SHALL be a sub-module alu_shift_add_mul (start, busy, done, product).

Verification
REQ-032 NrOfBits=32, SettleCycles=1: OpCode=0, MuxOut returns 32'h1234 -> ResultValid 2 cycles after accept, Result=32'h1234, Zero=0.
REQ-033 SettleCycles=3, MuxOut=0 -> ResultValid 4 cycles after accept, Zero=1, Sel=0 held throughout.
REQ-034 MUL_EN, OpCode=F, A=7, B=6, MuxOut looped from MulOut -> Result=42 at 34 cycles; A=B=32'hFFFF_FFFF -> Result=32'h0000_0001.
REQ-035 ResultReady held low 5 cycles -> ResultValid/Result stable, ReqReady=0, second ReqValid ignored.
REQ-036 Reset_n low during MUL step 10 -> next cycle IDLE, ResultValid=0, MuxEnable=0, Zero=1.
REQ-037 Macro undefined, OpCode=F -> latency SettleCycles+1, Result=MuxOut.
